register_nbits: RTL and testbench
=================================

REGISTER_NBITS -- requirements
Module: register_nbits

Interface
REQ-001 The block SHALL have one parameter: N, default 8, data width in bits; legal values are N >= 1.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port load, input, 1 bit: write enable, sampled at the rising edge of clk.
REQ-005 The block SHALL have port in, input, N bits: data to store.
REQ-006 The block SHALL have port out, output, N bits: the registered value, driven directly from the storage flops with no combinational path from any input.

Function
REQ-007 While rst=1, out SHALL be all-zeros, regardless of clk, load and in.
REQ-008 On a rising clk edge with rst=0 and load=1, out SHALL take the value of in sampled at that edge; latency is 1 cycle, and the new value is visible after the edge.
REQ-009 On a rising clk edge with rst=0 and load=0, out SHALL hold its previous value.
REQ-010 If rst and load are both 1, rst SHALL win and out SHALL stay zero.
REQ-011 A change on in or load between clock edges SHALL NOT change out.
REQ-012 All N bits SHALL load and clear together; there is no partial-width write, wrap-around or arithmetic.
REQ-013 On the first rising edge after rst deasserts, the register SHALL load normally if load=1 at that edge; there is no extra recovery cycle.

Reset
REQ-014 rst SHALL clear out to zero immediately on assertion, including assertion mid-cycle, without waiting for a clk edge.
REQ-015 The reset value SHALL be zero for every N.
REQ-016 Reset deassertion is intended to be synchronous to clk externally; the block SHALL add no synchronizer.
REQ-017 Before the first reset, out SHALL be treated as undefined by verification.

Structure
REQ-018 The block SHALL be a single flat module with no shared package; the width comes only from parameter N.
REQ-019 The block SHALL instantiate no sub-modules; it SHALL be one always-block modelling an N-bit flop bank with asynchronous clear and clock enable.
REQ-020 The block SHALL synthesize to N flops with asynchronous reset plus an enable mux, with no latches.

Verification
REQ-021 Scenario: N=8, rst=1 pulse then rst=0, load=0 for 2 cycles -> out=0x00 throughout.
REQ-022 Scenario: load=1, in=0x04 set before a rising edge, then load=0 and in=0x00 for 2 cycles -> out=0x04 after that edge and holds 0x04.
REQ-023 Scenario: out=0x04, rst asserted 3 ns before a rising edge (mid-cycle) -> out=0x00 at the moment of assertion, not at the next edge.
REQ-024 Scenario: rst deasserted mid-cycle with load=1, in=0x02 -> out=0x02 after the next rising edge.
REQ-025 Scenario: rst=1 and load=1, in=0xFF across several edges -> out remains 0x00.
REQ-026 Scenario: load=1, in toggling between edges (0xAA then 0x55 before the edge) -> out equals only the value present at the edge (0x55), with no glitches between edges.

Source files
------------

// File: rtl/register_nbits.sv
// N-bit register with asynchronous active-high clear and a load enable.
// The output comes straight from the flop bank.
module register_nbits #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] in,
    output logic [N-1:0] out
);

    logic [N-1:0] r_q;

    // Reset beats load; without load the flops keep their value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_q <= '0;
        else if (load)
            r_q <= in;
    end

    assign out = r_q;

endmodule

// File: tb/tb_register_nbits.sv
// Directed scoreboard bench for register_nbits at N=8 and N=1.
// Expected values are queued as stimulus is driven and popped at each check.
module tb_register_nbits;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] in;
    logic [7:0] out;
    logic [0:0] out1;

    logic [7:0] exp_q[$];
    logic [7:0] m;
    int         n_pass;
    int         n_total;

    register_nbits #(.N(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .in   (in),
        .out  (out)
    );

    register_nbits #(.N(1)) dut1 (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .in   (in[0:0]),
        .out  (out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [7:0] e);
        exp_q.push_back(e);
    endtask

    // Pop the oldest expectation and compare both widths against it.
    task automatic check(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            n_total++;
            $error("FAIL %s: scoreboard empty, got %h", tag, out);
            return;
        end
        e = exp_q.pop_front();
        n_total++;
        assert (out === e) n_pass++;
        else $error("FAIL %s: out=%h expected=%h", tag, out, e);
        n_total++;
        assert (out1 === e[0:0]) n_pass++;
        else $error("FAIL %s_n1: out=%b expected=%b", tag, out1, e[0]);
    endtask

    // Drive one cycle at the falling edge, model it, check after the rising edge.
    task automatic cycle(input logic r, input logic l,
                         input logic [7:0] d, input string tag);
        @(negedge clk);
        rst  = r;
        load = l;
        in   = d;
        if (r)      m = 8'h00;
        else if (l) m = d;
        push(m);
        @(posedge clk);
        #1;
        check(tag);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        m       = 8'h00;
        rst     = 1'b0;
        load    = 1'b0;
        in      = 8'h00;

        // Reset pulse with no clock edge involved.
        #2 rst = 1'b1;
        #1;
        push(8'h00);
        check("rst_assert");

        cycle(1'b1, 1'b0, 8'h00, "rst_held");
        cycle(1'b0, 1'b0, 8'h00, "idle0");
        cycle(1'b0, 1'b0, 8'h00, "idle1");

        cycle(1'b0, 1'b1, 8'h04, "load04");
        cycle(1'b0, 1'b0, 8'h00, "hold04_a");
        cycle(1'b0, 1'b0, 8'h00, "hold04_b");

        // Mid-cycle reset, 3 ns before the next rising edge.
        #6;
        rst = 1'b1;
        #1;
        push(8'h00);
        check("rst_midcycle");
        m = 8'h00;
        @(posedge clk);
        #1;
        push(8'h00);
        check("rst_after_edge");

        cycle(1'b1, 1'b1, 8'hFF, "rst_load_ff0");
        cycle(1'b1, 1'b1, 8'hFF, "rst_load_ff1");
        cycle(1'b1, 1'b1, 8'hFF, "rst_load_ff2");

        // Mid-cycle deassert with load pending.
        @(negedge clk);
        #1;
        rst  = 1'b0;
        load = 1'b1;
        in   = 8'h02;
        #1;
        push(8'h00);
        check("deassert_pre_edge");
        @(posedge clk);
        #1;
        push(8'h02);
        check("first_load_02");

        // Input toggles between edges; only the value at the edge lands.
        in = 8'hAA;
        #2;
        push(8'h02);
        check("no_glitch_aa");
        #3;
        in = 8'h55;
        #1;
        push(8'h02);
        check("no_glitch_55");
        @(posedge clk);
        #1;
        push(8'h55);
        check("load55_at_edge");
        m = 8'h55;

        cycle(1'b0, 1'b0, 8'h00, "hold55_a");
        cycle(1'b0, 1'b0, 8'hFF, "hold55_b");
        cycle(1'b0, 1'b1, 8'hFF, "loadff");
        cycle(1'b0, 1'b1, 8'h80, "load80");
        cycle(1'b0, 1'b1, 8'h01, "load01");

        // Load toggling between edges must not disturb the output.
        @(negedge clk);
        load = 1'b0;
        #2 load = 1'b1;
        #1 load = 1'b0;
        #1;
        push(8'h01);
        check("load_toggle_mid");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
